decode_mc: RTL and testbench
============================

Name: decode_mc

Overview:
- Next-generation control unit for the multicycle ARM datapath.
- Combines the main control FSM, the ALU decoder, PC logic and the instruction decoder in one block.
- Adds over the current unit: a memory-ready wait handshake, a parametrised multi-cycle multiply state, CMP decode, and fully defined (no X) decode defaults.
- Sits between the instruction register / flag logic and the datapath mux and enable controls.

Parameters:
- ALUCTRL_W, 3: width of ALUControl; the upper bits above [2:0] are zero.
- MUL_CYCLES, 4: number of cycles spent in MULEXEC; legal range 1..15.
- MEM_WAIT_EN, 1: 1 honours MemReady; 0 treats MemReady as constant 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20].
- MulFunct  in  4  instruction bits [7:4].
- Rd  in  4  destination register.
- MemReady  in  1  memory access completes this cycle.
- FlagW  out  2  [1] = NZ write enable, [0] = CV write enable.
- PCS  out  1  PC written from the result.
- NextPC  out  1  PC increment enable.
- RegW  out  1  register file write enable.
- MemW  out  1  memory write enable.
- IRWrite  out  1  instruction register load.
- AdrSrc  out  1  0 = PC, 1 = result.
- ResultSrc  out  2  result mux select.
- ALUSrcA  out  2  ALU A-operand select.
- ALUSrcB  out  2  ALU B-operand select.
- ImmSrc  out  2  immediate extend select.
- RegSrc  out  2  register address select.
- ALUControl  out  ALUCTRL_W  ALU operation.
- MulBusy  out  1  high while in MULEXEC.
- State  out  4  current state encoding, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, MULEXEC=10.
- All outputs are Moore/combinational from the state plus the decode inputs. Only the state register and the multiply counter are clocked.
- reset=0: State=FETCH and counter=0, asynchronously. This can happen mid-operation, e.g. in MULEXEC or MEMWRITE; no pending write survives.
- Outputs while in reset follow FETCH: IRWrite=NextPC=MemReady_eff, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegW=MemW=0, FlagW=00, ALUControl=0, MulBusy=0.
- FETCH outputs as listed above. Stays in FETCH until MemReady_eff, then goes to DECODE. IRWrite and NextPC are never asserted with MemReady_eff=0.
- DECODE outputs: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state:
  - Op=01 -> MEMADR.
  - Op=10 -> BRANCH.
  - Op=00 with Funct[5:4]=00 and MulFunct=1001 -> MULEXEC.
  - Op=00 otherwise -> EXECUTEI if Funct[5]=1, else EXECUTER.
  - Op=11 -> FETCH (NOP).
- MEMADR: ALUSrcA=00, ALUSrcB=01. Goes to MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady_eff, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegW=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1 held every cycle until MemReady_eff, then FETCH.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1. EXECUTEI is identical except ALUSrcB=01. Both go to ALUWB.
- MULEXEC: ALUSrcA=00, ALUSrcB=00, ALUOp=1, MulBusy=1.
  - Counter loads MUL_CYCLES-1 on entry and decrements each cycle.
  - Exits to ALUWB in the cycle the counter is 0, so MULEXEC lasts exactly MUL_CYCLES cycles.
- ALUWB: ResultSrc=00, ALUOp=1. RegW=1 except for compare ops (Funct[4:3]=10: TST/CMP/CMN). Then FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1, then FETCH.
- ALU decoder, active only when ALUOp=1; otherwise ALUControl=0 and FlagW=00.
  - MUL pattern: ALUControl=110, FlagW={Funct[0],0}.
  - Funct[4:1] map:
    - 0000 AND -> 010
    - 0001 EOR -> 100
    - 0010 SUB -> 001
    - 0100 ADD -> 000
    - 0101 ADC -> 000
    - 1000 TST -> 010
    - 1010 CMP -> 001
    - 1011 CMN -> 000
    - 1100 ORR -> 011
  - Any other code: ALUControl=0, FlagW=00.
  - For mapped codes, FlagW[1]=Funct[0]. FlagW[0]=Funct[0] only for codes 0010, 0100, 1010, 1011; otherwise 0.
- PCS = ((Rd==1111) & RegW) | Branch.
- ImmSrc = Op. RegSrc[0] = (Op==10). RegSrc[1] = (Op==01).

Test Plan:
- ADD R1 (Op=00, Funct=001000), MemReady=1 -> states 0,1,6,8,0. RegW=1 only in ALUWB. ALUControl=000, FlagW=00.
- MUL with S=1 (Funct=000001, MulFunct=1001), MUL_CYCLES=4 -> MULEXEC held for exactly 4 cycles with MulBusy=1 and ALUControl=110. FlagW=10 in ALUWB.
- LDR with MemReady=0 for 3 cycles in MEMREAD -> State stays 3 for those cycles, then MEMWB with RegW=1. MEM_WAIT_EN=0 variant -> no stall.
- CMP with S=1 (Funct=010101) -> FlagW=11 and ALUControl=001 in EXECUTER and ALUWB; RegW=0 in ALUWB.
- B (Op=10) -> PCS=1 in BRANCH. ADD with Rd=15 -> PCS=1 in ALUWB.
- reset driven to 0 in MULEXEC cycle 2 and again in MEMWRITE -> State=0 immediately, MemW=0, counter=0. Next instruction decodes normally.

Source files
------------

// File: rtl/decode_mc.sv
// decode_mc: multicycle ARM control unit combining the main FSM, ALU decoder,
// PC logic and instruction decoder, with memory-ready wait and multi-cycle multiply.
module decode_mc #(
  parameter int ALUCTRL_W   = 3,
  parameter int MUL_CYCLES  = 4,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           MulFunct,
  input  logic [3:0]           Rd,
  input  logic                 MemReady,
  output logic [1:0]           FlagW,
  output logic                 PCS,
  output logic                 NextPC,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 MulBusy,
  output logic [3:0]           State
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    MULEXEC  = 4'd10
  } state_t;
  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic       w_mr, w_mul, w_aluop, w_branch, w_hit, w_arith;
  logic [2:0] w_alu;
  assign w_mr  = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;
  assign w_mul = (Op == 2'b00) && (Funct[5:4] == 2'b00) && (MulFunct == 4'b1001);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= FETCH;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == MULEXEC) ? ((r_state == MULEXEC) ? r_cnt - 4'd1 : 4'(MUL_CYCLES - 1)) : 4'd0;
    end
  always_comb begin
    w_next    = FETCH;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegW      = 1'b0;
    MemW      = 1'b0;
    w_aluop   = 1'b0;
    w_branch  = 1'b0;
    MulBusy   = 1'b0;
    case (r_state)
      FETCH: begin
        IRWrite   = w_mr;
        NextPC    = w_mr;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_next    = w_mr ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_next    = (Op == 2'b01) ? MEMADR :
                    (Op == 2'b10) ? BRANCH :
                    (Op == 2'b11) ? FETCH  :
                    w_mul         ? MULEXEC :
                    Funct[5]      ? EXECUTEI : EXECUTER;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        w_next  = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = w_mr ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        w_next = w_mr ? FETCH : MEMWRITE;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB = (r_state == EXECUTEI) ? 2'b01 : 2'b00;
        w_aluop = 1'b1;
        w_next  = ALUWB;
      end
      MULEXEC: begin
        w_aluop = 1'b1;
        MulBusy = 1'b1;
        w_next  = (r_cnt == 4'd0) ? ALUWB : MULEXEC;
      end
      ALUWB: begin
        w_aluop = 1'b1;
        RegW    = (Funct[4:3] != 2'b10);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end
  always_comb begin
    w_hit = 1'b1;
    case (Funct[4:1])
      4'b0000: w_alu = 3'b010;
      4'b0001: w_alu = 3'b100;
      4'b0010: w_alu = 3'b001;
      4'b0100: w_alu = 3'b000;
      4'b0101: w_alu = 3'b000;
      4'b1000: w_alu = 3'b010;
      4'b1010: w_alu = 3'b001;
      4'b1011: w_alu = 3'b000;
      4'b1100: w_alu = 3'b011;
      default: begin
        w_alu = 3'b000;
        w_hit = 1'b0;
      end
    endcase
    w_arith = (Funct[4:1] == 4'b0010) || (Funct[4:1] == 4'b0100) ||
              (Funct[4:1] == 4'b1010) || (Funct[4:1] == 4'b1011);
  end
  assign ALUControl = !w_aluop ? '0 : w_mul ? ALUCTRL_W'(3'b110) : ALUCTRL_W'(w_alu);
  assign FlagW      = !w_aluop ? 2'b00 : w_mul ? {Funct[0], 1'b0} :
                      w_hit ? {Funct[0], Funct[0] & w_arith} : 2'b00;
  assign PCS        = ((Rd == 4'hf) && RegW) || w_branch;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign State      = r_state;
endmodule

// File: tb/tb_decode_mc.sv
// tb_decode_mc: directed tests of decode_mc sequencing, decode, wait and reset behaviour.
module tb_decode_mc;
  logic       clk, reset, rst0_n, MemReady;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] MulFunct, Rd;
  logic [1:0] FlagW, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, MulBusy;
  logic [2:0] ALUControl;
  logic [3:0] State;
  logic [1:0] z_FlagW, z_ResultSrc, z_ALUSrcA, z_ALUSrcB, z_ImmSrc, z_RegSrc;
  logic       z_PCS, z_NextPC, z_RegW, z_MemW, z_IRWrite, z_AdrSrc, z_MulBusy;
  logic [2:0] z_ALUControl;
  logic [3:0] z_State;
  int total = 0, bad = 0;

  decode_mc #(.ALUCTRL_W(3), .MUL_CYCLES(4), .MEM_WAIT_EN(1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MulFunct(MulFunct), .Rd(Rd),
    .MemReady(MemReady), .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .MulBusy(MulBusy), .State(State));

  decode_mc #(.ALUCTRL_W(3), .MUL_CYCLES(4), .MEM_WAIT_EN(0)) dut0 (
    .clk(clk), .reset(rst0_n), .Op(Op), .Funct(Funct), .MulFunct(MulFunct), .Rd(Rd),
    .MemReady(MemReady), .FlagW(z_FlagW), .PCS(z_PCS), .NextPC(z_NextPC), .RegW(z_RegW),
    .MemW(z_MemW), .IRWrite(z_IRWrite), .AdrSrc(z_AdrSrc), .ResultSrc(z_ResultSrc),
    .ALUSrcA(z_ALUSrcA), .ALUSrcB(z_ALUSrcB), .ImmSrc(z_ImmSrc), .RegSrc(z_RegSrc),
    .ALUControl(z_ALUControl), .MulBusy(z_MulBusy), .State(z_State));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [1:0] op, input logic [5:0] f, input logic [3:0] mf, input logic [3:0] rd);
    Op = op; Funct = f; MulFunct = mf; Rd = rd;
  endtask

  task automatic test_reset;
    reset = 1'b0; rst0_n = 1'b0; MemReady = 1'b0;
    set_in(2'b00, 6'd0, 4'd0, 4'd0);
    #2;
    total++; if (State !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", State); end
    total++; if ({IRWrite, NextPC} !== 2'b00) begin bad++; $display("FAIL reset_irwrite_noready got=%b exp=00", {IRWrite, NextPC}); end
    total++; if ({ALUSrcA, ALUSrcB, ResultSrc, AdrSrc} !== 7'b0110100) begin bad++; $display("FAIL reset_mux got=%b exp=0110100", {ALUSrcA, ALUSrcB, ResultSrc, AdrSrc}); end
    total++; if ({RegW, MemW, FlagW, ALUControl, MulBusy} !== 8'd0) begin bad++; $display("FAIL reset_enables got=%b exp=0", {RegW, MemW, FlagW, ALUControl, MulBusy}); end
    MemReady = 1'b1;
    #1;
    total++; if ({IRWrite, NextPC} !== 2'b11) begin bad++; $display("FAIL reset_irwrite_ready got=%b exp=11", {IRWrite, NextPC}); end
    tick;
    total++; if (State !== 4'd0) begin bad++; $display("FAIL reset_hold got=%0d exp=0", State); end
    reset = 1'b1;
  endtask

  task automatic run_add(input logic [3:0] rd);
    int st[5] = '{0, 1, 6, 8, 0};
    int rw[5] = '{0, 0, 0, 1, 0};
    set_in(2'b00, 6'b001000, 4'd0, rd);
    for (int i = 0; i < 5; i++) begin
      total++; if (State !== st[i]) begin bad++; $display("FAIL add_state[%0d] got=%0d exp=%0d", i, State, st[i]); end
      total++; if (RegW !== rw[i][0]) begin bad++; $display("FAIL add_regw[%0d] got=%b exp=%b", i, RegW, rw[i][0]); end
      total++; if ({ALUControl, FlagW} !== 5'd0) begin bad++; $display("FAIL add_alu[%0d] got=%b exp=00000", i, {ALUControl, FlagW}); end
      total++; if (PCS !== (rw[i][0] && rd == 4'hf)) begin bad++; $display("FAIL add_pcs[%0d] got=%b exp=%b", i, PCS, rw[i][0] && rd == 4'hf); end
      if (i == 2) begin
        total++; if ({ALUSrcA, ALUSrcB} !== 4'b0000) begin bad++; $display("FAIL add_src got=%b exp=0000", {ALUSrcA, ALUSrcB}); end
      end
      if (i < 4) tick;
    end
  endtask

  task automatic run_mul;
    int st[8] = '{0, 1, 10, 10, 10, 10, 8, 0};
    int mb[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    int ac[8] = '{0, 0, 6, 6, 6, 6, 6, 0};
    int fw[8] = '{0, 0, 2, 2, 2, 2, 2, 0};
    set_in(2'b00, 6'b000001, 4'b1001, 4'd2);
    for (int i = 0; i < 8; i++) begin
      total++; if (State !== st[i]) begin bad++; $display("FAIL mul_state[%0d] got=%0d exp=%0d", i, State, st[i]); end
      total++; if (MulBusy !== mb[i][0]) begin bad++; $display("FAIL mul_busy[%0d] got=%b exp=%b", i, MulBusy, mb[i][0]); end
      total++; if (ALUControl !== ac[i]) begin bad++; $display("FAIL mul_aluctl[%0d] got=%b exp=%0d", i, ALUControl, ac[i]); end
      total++; if (FlagW !== fw[i]) begin bad++; $display("FAIL mul_flagw[%0d] got=%b exp=%0d", i, FlagW, fw[i]); end
      total++; if (RegW !== (i == 6)) begin bad++; $display("FAIL mul_regw[%0d] got=%b exp=%b", i, RegW, i == 6); end
      if (i < 7) tick;
    end
  endtask

  task automatic test_add;
    run_add(4'd1);
  endtask

  task automatic test_mul;
    run_mul;
  endtask

  task automatic test_ldr_wait;
    set_in(2'b01, 6'b011001, 4'd0, 4'd3);
    total++; if (State !== 4'd0) begin bad++; $display("FAIL ldr_fetch got=%0d exp=0", State); end
    tick;
    total++; if ({ImmSrc, RegSrc} !== 4'b0110) begin bad++; $display("FAIL ldr_decode_imm got=%b exp=0110", {ImmSrc, RegSrc}); end
    tick;
    total++; if ({State, ALUSrcA, ALUSrcB} !== {4'd2, 4'b0001}) begin bad++; $display("FAIL ldr_memadr got=%b exp=%b", {State, ALUSrcA, ALUSrcB}, {4'd2, 4'b0001}); end
    tick;
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if ({State, AdrSrc, ResultSrc} !== {4'd3, 3'b100}) begin bad++; $display("FAIL ldr_stall[%0d] got=%b exp=%b", i, {State, AdrSrc, ResultSrc}, {4'd3, 3'b100}); end
      tick;
    end
    MemReady = 1'b1;
    total++; if (State !== 4'd3) begin bad++; $display("FAIL ldr_stall_end got=%0d exp=3", State); end
    tick;
    total++; if ({State, RegW, ResultSrc} !== {4'd4, 3'b101}) begin bad++; $display("FAIL ldr_memwb got=%b exp=%b", {State, RegW, ResultSrc}, {4'd4, 3'b101}); end
    tick;
    total++; if (State !== 4'd0) begin bad++; $display("FAIL ldr_done got=%0d exp=0", State); end
  endtask

  task automatic test_nowait;
    int st[6] = '{0, 1, 2, 3, 4, 0};
    reset = 1'b0; MemReady = 1'b0;
    set_in(2'b01, 6'b011001, 4'd0, 4'd3);
    rst0_n = 1'b1;
    #1;
    total++; if ({z_IRWrite, z_NextPC} !== 2'b11) begin bad++; $display("FAIL nowait_irwrite got=%b exp=11", {z_IRWrite, z_NextPC}); end
    for (int i = 0; i < 6; i++) begin
      total++; if (z_State !== st[i]) begin bad++; $display("FAIL nowait_state[%0d] got=%0d exp=%0d", i, z_State, st[i]); end
      if (i < 5) tick;
    end
    total++; if ({State, IRWrite} !== 5'd0) begin bad++; $display("FAIL nowait_main_held got=%b exp=00000", {State, IRWrite}); end
    rst0_n = 1'b0; MemReady = 1'b1; reset = 1'b1;
  endtask

  task automatic test_cmp;
    int st[5] = '{0, 1, 6, 8, 0};
    set_in(2'b00, 6'b010101, 4'd0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      total++; if (State !== st[i]) begin bad++; $display("FAIL cmp_state[%0d] got=%0d exp=%0d", i, State, st[i]); end
      if (i == 2 || i == 3) begin
        total++; if ({ALUControl, FlagW, RegW} !== 6'b001110) begin bad++; $display("FAIL cmp_dec[%0d] got=%b exp=001110", i, {ALUControl, FlagW, RegW}); end
      end
      if (i < 4) tick;
    end
  endtask

  task automatic test_branch;
    set_in(2'b10, 6'b101000, 4'd0, 4'd0);
    tick;
    total++; if ({State, PCS, ImmSrc, RegSrc} !== {4'd1, 5'b01001}) begin bad++; $display("FAIL br_decode got=%b exp=%b", {State, PCS, ImmSrc, RegSrc}, {4'd1, 5'b01001}); end
    tick;
    total++; if ({State, PCS, RegW, ALUSrcB, ResultSrc} !== {4'd9, 6'b100110}) begin bad++; $display("FAIL br_branch got=%b exp=%b", {State, PCS, RegW, ALUSrcB, ResultSrc}, {4'd9, 6'b100110}); end
    tick;
    total++; if ({State, PCS} !== 5'd0) begin bad++; $display("FAIL br_done got=%b exp=00000", {State, PCS}); end
  endtask

  task automatic test_pc_add;
    run_add(4'hf);
  endtask

  task automatic test_nop_undef;
    set_in(2'b11, 6'b000000, 4'd0, 4'd0);
    tick;
    total++; if (State !== 4'd1) begin bad++; $display("FAIL nop_decode got=%0d exp=1", State); end
    tick;
    total++; if (State !== 4'd0) begin bad++; $display("FAIL nop_fetch got=%0d exp=0", State); end
    set_in(2'b00, 6'b100111, 4'd0, 4'd0);
    tick;
    tick;
    total++; if ({State, ALUControl, FlagW} !== {4'd7, 5'd0}) begin bad++; $display("FAIL undef_exec got=%b exp=%b", {State, ALUControl, FlagW}, {4'd7, 5'd0}); end
    tick;
    total++; if ({State, ALUControl, FlagW} !== {4'd8, 5'd0}) begin bad++; $display("FAIL undef_wb got=%b exp=%b", {State, ALUControl, FlagW}, {4'd8, 5'd0}); end
    tick;
    set_in(2'b00, 6'b111001, 4'd0, 4'd0);
    tick;
    tick;
    total++; if ({State, ALUSrcB, ALUControl, FlagW} !== {4'd7, 2'b01, 3'b011, 2'b10}) begin bad++; $display("FAIL orrs_exec got=%b exp=%b", {State, ALUSrcB, ALUControl, FlagW}, {4'd7, 2'b01, 3'b011, 2'b10}); end
    tick;
    tick;
  endtask

  task automatic test_reset_mid;
    set_in(2'b00, 6'b000001, 4'b1001, 4'd2);
    tick;
    tick;
    tick;
    total++; if ({State, MulBusy} !== {4'd10, 1'b1}) begin bad++; $display("FAIL mid_mul2 got=%b exp=%b", {State, MulBusy}, {4'd10, 1'b1}); end
    reset = 1'b0;
    #1;
    total++; if ({State, MulBusy, ALUControl} !== 8'd0) begin bad++; $display("FAIL mid_mul_rst got=%b exp=0", {State, MulBusy, ALUControl}); end
    tick;
    total++; if (State !== 4'd0) begin bad++; $display("FAIL mid_mul_hold got=%0d exp=0", State); end
    reset = 1'b1;
    run_mul;
    set_in(2'b01, 6'b011000, 4'd0, 4'd0);
    tick;
    tick;
    tick;
    total++; if ({State, MemW, AdrSrc} !== {4'd5, 2'b11}) begin bad++; $display("FAIL mid_memwrite got=%b exp=%b", {State, MemW, AdrSrc}, {4'd5, 2'b11}); end
    MemReady = 1'b0;
    tick;
    total++; if ({State, MemW} !== {4'd5, 1'b1}) begin bad++; $display("FAIL mid_memwrite_wait got=%b exp=%b", {State, MemW}, {4'd5, 1'b1}); end
    reset = 1'b0;
    #1;
    total++; if ({State, MemW} !== 5'd0) begin bad++; $display("FAIL mid_memwrite_rst got=%b exp=00000", {State, MemW}); end
    MemReady = 1'b1;
    tick;
    reset = 1'b1;
    run_add(4'd1);
  endtask

  initial begin
    test_reset;
    test_add;
    test_mul;
    test_ldr_wait;
    test_nowait;
    test_cmp;
    test_branch;
    test_pc_add;
    test_nop_undef;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
